tape_ram_scheduler: RTL and testbench

Sequences a .TAP load into main RAM and shares the RAM write port between the CPU and the tape loader's byte stream. It captures loader writes into a small FIFO and drains them only in RAM slots the video/CPU phase marks as free. It holds the CPU while a load is in progress. After the last byte is committed, it releases the CPU and issues the autorun request. It sits between the cassette loader outputs, the CPU RAM bus and the RAM write port.

---
 rtl/tape_ram_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_tape_ram_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_ram_scheduler.sv
// Tape-load RAM scheduler: buffers loader writes in a small FIFO, drains them
// into free RAM slots, holds the CPU during a load and issues done/autorun.
module tape_ram_scheduler #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        tape_wr,
    input  logic [15:0] tape_addr,
    input  logic [7:0]  tape_dout,
    input  logic        tape_complete,
    input  logic        autostart,
    input  logic        slot_free,
    input  logic        cpu_ram_we,
    input  logic [15:0] cpu_ram_addr,
    input  logic [7:0]  cpu_ram_din,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        autorun_req,
    output logic        load_abort,
    output logic        fifo_overflow
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 24;
    localparam int unsigned SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADING,
        S_DRAIN,
        S_SETTLE,
        S_RELEASE
    } state_t;

    state_t                 state;
    logic                   dl_q;
    logic                   tc_q;
    logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   have_last;
    logic [15:0]            last_addr;
    logic                   ok_q;
    logic                   auto_q;
    logic [SET_W-1:0]       settle_cnt;

    logic                   dl_rise;
    logic                   dl_fall;
    logic                   tc_rise;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   capture;
    logic                   push;
    logic                   drop;
    logic                   drain_done;
    logic [ENTRY_W-1:0]     head;

    // Edge detection, capture qualification and FIFO handshakes
    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign tc_rise    = tape_complete & ~tc_q;
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = slot_free & ~fifo_empty;
    assign capture    = (state == S_LOADING) & tape_wr &
                        (~have_last | (tape_addr != last_addr));
    assign push       = capture & (~fifo_full | pop);
    assign drop       = capture & fifo_full & ~pop;
    // FIFO is empty after this cycle (no pushes happen outside LOADING)
    assign drain_done = fifo_empty | ((count == CNT_W'(1)) & pop);
    assign head       = mem[rd_ptr];

    // RAM port mux: a FIFO pop owns the port, otherwise the CPU passes through
    assign ram_we   = pop ? 1'b1         : cpu_ram_we;
    assign ram_addr = pop ? head[23:8]   : cpu_ram_addr;
    assign ram_din  = pop ? head[7:0]    : cpu_ram_din;

    // Registered copies of the level inputs for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_q <= 1'b0;
            tc_q <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            tc_q <= tape_complete;
        end
    end

    // FIFO storage (contents need no reset; validity is tracked by count)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tape_addr, tape_dout};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Load sequencing FSM with registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cpu_hold      <= 1'b0;
            load_done     <= 1'b0;
            autorun_req   <= 1'b0;
            load_abort    <= 1'b0;
            fifo_overflow <= 1'b0;
            have_last     <= 1'b0;
            last_addr     <= '0;
            ok_q          <= 1'b0;
            auto_q        <= 1'b0;
            settle_cnt    <= '0;
        end else begin
            load_done   <= 1'b0;
            autorun_req <= 1'b0;
            if (drop) begin
                fifo_overflow <= 1'b1;
            end
            if (capture) begin
                have_last <= 1'b1;
                last_addr <= tape_addr;
            end
            case (state)
                S_IDLE: begin
                    cpu_hold <= 1'b0;
                    if (dl_rise) begin
                        state         <= S_LOADING;
                        cpu_hold      <= 1'b1;
                        load_abort    <= 1'b0;
                        fifo_overflow <= 1'b0;
                        have_last     <= 1'b0;
                    end
                end
                S_LOADING: begin
                    // a completion edge wins over a simultaneous download drop
                    if (tc_rise) begin
                        state  <= S_DRAIN;
                        ok_q   <= 1'b1;
                        auto_q <= autostart;
                    end else if (dl_fall) begin
                        state      <= S_DRAIN;
                        ok_q       <= 1'b0;
                        auto_q     <= 1'b0;
                        load_abort <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state      <= S_SETTLE;
                        settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state       <= S_RELEASE;
                        cpu_hold    <= 1'b0;
                        load_done   <= ok_q;
                        autorun_req <= ok_q & auto_q;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tape_ram_scheduler.sv
// Scoreboard bench for tape_ram_scheduler: expected RAM commits queued at
// stimulus time, observed commits collected by a monitor and compared.
`timescale 1ns/1ps
module tb_tape_ram_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download, tape_wr, tape_complete, autostart, slot_free;
    logic [15:0] tape_addr, cpu_ram_addr;
    logic [7:0]  tape_dout, cpu_ram_din;
    logic        cpu_ram_we;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        cpu_hold, load_done, autorun_req, load_abort, fifo_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int obs_cyc  = 0;
    int ld_cnt   = 0;
    int ar_cnt   = 0;
    int ld_cyc   = 0;
    int ar_cyc   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    tape_ram_scheduler #(.FIFO_DEPTH(4), .SETTLE_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .tape_wr(tape_wr), .tape_addr(tape_addr), .tape_dout(tape_dout),
        .tape_complete(tape_complete), .autostart(autostart), .slot_free(slot_free),
        .cpu_ram_we(cpu_ram_we), .cpu_ram_addr(cpu_ram_addr), .cpu_ram_din(cpu_ram_din),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .cpu_hold(cpu_hold), .load_done(load_done), .autorun_req(autorun_req),
        .load_abort(load_abort), .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record FIFO-sourced RAM writes and status pulses
    always @(negedge clk) begin
        if (ram_we && !cpu_ram_we) begin
            obs_q.push_back({ram_addr, ram_din});
            obs_cyc = cyc;
        end
        if (load_done)   begin ld_cnt++; ld_cyc = cyc; end
        if (autorun_req) begin ar_cnt++; ar_cyc = cyc; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] d, input bit commit);
        tape_wr   = 1'b1;
        tape_addr = a;
        tape_dout = d;
        if (commit) exp_q.push_back({a, d});
        step();
    endtask

    task automatic start_load();
        ioctl_download = 1'b1;
        step();
    endtask

    task automatic complete_load();
        tape_complete = 1'b1;
        step();
        ioctl_download = 1'b0;
        tape_complete  = 1'b0;
    endtask

    task automatic wait_release(output int rel_cyc, output bit timed_out);
        timed_out = 1'b1;
        rel_cyc   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cpu_hold) begin
                rel_cyc   = cyc;
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({cpu_hold, load_done, autorun_req, load_abort, fifo_overflow, ram_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {cpu_hold, load_done, autorun_req, load_abort, fifo_overflow, ram_we});
        end
    endtask

    task automatic test_basic_load();
        int rel; bit to; logic [23:0] e, o;
        exp_q.delete(); obs_q.delete();
        autostart = 1'b1; slot_free = 1'b1;
        start_load();
        n_checks++;
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL t1_hold_start: got %b expected 1", cpu_hold); end
        send(16'h0500, 8'hA1, 1'b1);
        send(16'h0501, 8'hB2, 1'b1);
        send(16'h0502, 8'hC3, 1'b1);
        tape_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL t1_hold_loading: got %b expected 1", cpu_hold); end
        end
        complete_load();
        wait_release(rel, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL t1_release_timeout: cpu_hold stuck at 1, expected release"); end
        n_checks++;
        if ({load_done, autorun_req} !== 2'b11) begin
            n_fail++; $display("FAIL t1_pulses: got done/autorun %b expected 11", {load_done, autorun_req});
        end
        step(); step();
        n_checks++;
        if (ld_cnt !== 1 || ar_cnt !== 1 || ld_cyc !== ar_cyc) begin
            n_fail++; $display("FAIL t1_pulse_count: got done=%0d autorun=%0d (cyc %0d/%0d) expected 1/1 same cycle",
                               ld_cnt, ar_cnt, ld_cyc, ar_cyc);
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL t1_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL t1_write: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_duplicate_addr();
        int rel; bit to; logic [23:0] e, o;
        exp_q.delete(); obs_q.delete();
        autostart = 1'b0; slot_free = 1'b1;
        start_load();
        exp_q.push_back({16'h0600, 8'h11});
        tape_wr = 1'b1; tape_addr = 16'h0600; tape_dout = 8'h11;
        for (int i = 0; i < 5; i++) step();
        tape_wr = 1'b0;
        step(); step(); step();
        complete_load();
        wait_release(rel, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL t2_release_timeout: cpu_hold stuck at 1, expected release"); end
        n_checks++;
        if ({load_done, autorun_req} !== 2'b10) begin
            n_fail++; $display("FAIL t2_pulses: got done/autorun %b expected 10", {load_done, autorun_req});
        end
        step(); step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL t2_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL t2_write: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_overflow();
        int rel; bit to; logic [23:0] e, o;
        exp_q.delete(); obs_q.delete();
        autostart = 1'b0; slot_free = 1'b0;
        start_load();
        for (int i = 0; i < 6; i++) send(16'h0700 + 16'(i), 8'h40 + 8'(i), (i < 4));
        tape_wr = 1'b0;
        step();
        n_checks++;
        if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL t3_overflow_set: got %b expected 1", fifo_overflow); end
        cpu_ram_we = 1'b1; cpu_ram_addr = 16'h1234; cpu_ram_din = 8'h5A;
        @(negedge clk);
        n_checks++;
        if ({ram_we, ram_addr, ram_din} !== {1'b1, 16'h1234, 8'h5A}) begin
            n_fail++; $display("FAIL t3_cpu_passthru: got %b/%h/%h expected 1/1234/5a", ram_we, ram_addr, ram_din);
        end
        step();
        cpu_ram_we = 1'b0;
        complete_load();
        slot_free = 1'b1;
        wait_release(rel, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL t3_release_timeout: cpu_hold stuck at 1, expected release"); end
        n_checks++;
        if (rel - obs_cyc !== 17) begin
            n_fail++; $display("FAIL t3_settle_latency: got %0d cycles expected 17", rel - obs_cyc);
        end
        n_checks++;
        if (load_done !== 1'b1) begin n_fail++; $display("FAIL t3_done: got %b expected 1", load_done); end
        step(); step();
        n_checks++;
        if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL t3_overflow_sticky: got %b expected 1", fifo_overflow); end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL t3_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL t3_write: got %h expected %h", o, e); end
        end
        start_load();
        n_checks++;
        if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL t3_overflow_clear: got %b expected 0", fifo_overflow); end
        complete_load();
        wait_release(rel, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL t3_release2_timeout: cpu_hold stuck at 1, expected release"); end
        step(); step();
    endtask

    task automatic test_abort();
        int rel, ld0, ar0; bit to; logic [23:0] e, o;
        exp_q.delete(); obs_q.delete();
        autostart = 1'b1; slot_free = 1'b1;
        ld0 = ld_cnt; ar0 = ar_cnt;
        start_load();
        send(16'h0800, 8'h21, 1'b1);
        send(16'h0801, 8'h22, 1'b1);
        tape_wr = 1'b0;
        step();
        ioctl_download = 1'b0;
        step();
        n_checks++;
        if (load_abort !== 1'b1) begin n_fail++; $display("FAIL t4_abort_set: got %b expected 1", load_abort); end
        wait_release(rel, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL t4_release_timeout: cpu_hold stuck at 1, expected release"); end
        step(); step();
        n_checks++;
        if (ld_cnt !== ld0 || ar_cnt !== ar0) begin
            n_fail++; $display("FAIL t4_no_pulses: got done=%0d autorun=%0d expected %0d/%0d", ld_cnt, ar_cnt, ld0, ar0);
        end
        n_checks++;
        if ({cpu_hold, load_abort} !== 2'b01) begin
            n_fail++; $display("FAIL t4_final: got hold/abort %b expected 01", {cpu_hold, load_abort});
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL t4_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL t4_write: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_full_push_pop();
        int rel; bit to; logic [23:0] e, o;
        exp_q.delete(); obs_q.delete();
        autostart = 1'b0; slot_free = 1'b0;
        start_load();
        n_checks++;
        if (load_abort !== 1'b0) begin n_fail++; $display("FAIL t5_abort_clear: got %b expected 0", load_abort); end
        for (int i = 0; i < 4; i++) send(16'h0900 + 16'(i), 8'h60 + 8'(i), 1'b1);
        slot_free = 1'b1;
        send(16'h0904, 8'h64, 1'b1);
        tape_wr = 1'b0;
        step();
        n_checks++;
        if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL t5_no_overflow: got %b expected 0", fifo_overflow); end
        complete_load();
        wait_release(rel, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL t5_release_timeout: cpu_hold stuck at 1, expected release"); end
        step(); step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL t5_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL t5_write: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_load();
        int ld0, ar0;
        exp_q.delete(); obs_q.delete();
        autostart = 1'b1; slot_free = 1'b0;
        ld0 = ld_cnt; ar0 = ar_cnt;
        start_load();
        send(16'h0A00, 8'h71, 1'b0);
        send(16'h0A01, 8'h72, 1'b0);
        tape_wr = 1'b0;
        step();
        n_checks++;
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL t6_hold_before: got %b expected 1", cpu_hold); end
        #2;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        n_checks++;
        if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL t6_async_hold: got %b expected 0", cpu_hold); end
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        slot_free = 1'b1;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (obs_q.size() !== 0) begin n_fail++; $display("FAIL t6_no_writes: got %0d writes expected 0", obs_q.size()); end
        n_checks++;
        if ({cpu_hold, load_done, autorun_req, load_abort, fifo_overflow} !== 5'b0) begin
            n_fail++; $display("FAIL t6_outputs: got %b expected 00000",
                               {cpu_hold, load_done, autorun_req, load_abort, fifo_overflow});
        end
        n_checks++;
        if (ld_cnt !== ld0 || ar_cnt !== ar0) begin
            n_fail++; $display("FAIL t6_no_pulses: got done=%0d autorun=%0d expected %0d/%0d", ld_cnt, ar_cnt, ld0, ar0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ioctl_download = 1'b0; tape_wr = 1'b0; tape_complete = 1'b0; autostart = 1'b0;
        slot_free = 1'b0; tape_addr = '0; tape_dout = '0;
        cpu_ram_we = 1'b0; cpu_ram_addr = '0; cpu_ram_din = '0;
        #12;
        reset_n = 1'b1;
        step();
        test_reset();
        test_basic_load();
        test_duplicate_addr();
        test_overflow();
        test_abort();
        test_full_push_pop();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
